// File: rtl/sram_arb_2p_pkg.sv
// Shared definitions for the two-port SRAM arbiter: geometry defaults,
// the port-index type and the registered response tag.
package sram_arb_2p_pkg;
  localparam int SRAM_ADDR_WIDTH = 13;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_BE_WIDTH   = SRAM_DATA_WIDTH / 8;

  typedef logic port_t;
  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  typedef struct packed {
    logic  valid;
    port_t port;
    logic  we;
  } rsp_tag_t;
endpackage

// File: rtl/sram_arb_2p_arb.sv
// Two-requester arbiter: combinational grant plus the last_grant register
// that steers round-robin conflicts (fixed priority to port 0 when RR_EN=0).
module rr_arb2
  import sram_arb_2p_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_t      last_grant
);

  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          // On conflict the port that did not win last time goes first.
          if ((RR_EN != 0) && (last_grant == PORT0)) gnt = 2'b10;
          else                                       gnt = 2'b01;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset to PORT1 so that port 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst_i)             last_grant <= PORT1;
    else if (gnt != 2'b00) last_grant <= gnt[1];
  end

endmodule

// File: rtl/sram_arb_2p.sv
// Two-port arbiter in front of a single-port SRAM macro. Valid/ready: a port
// holds req until gnt; gnt is same-cycle, rvalid follows exactly one cycle later.
module sram_arb_2p
  import sram_arb_2p_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int RR_EN      = 1
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    p0_req_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [ADDR_WIDTH+1:0]   p0_addr_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  input  logic                    p1_req_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [ADDR_WIDTH+1:0]   p1_addr_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p0_gnt_o,
  output logic                    p1_gnt_o,
  output logic                    p0_rvalid_o,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    sram_cen_o,
  output logic                    sram_gwen_o,
  output logic [DATA_WIDTH/8-1:0] sram_ben_o,
  output logic [ADDR_WIDTH-1:0]   sram_a_o,
  output logic [DATA_WIDTH-1:0]   sram_d_o,
  input  logic [DATA_WIDTH-1:0]   sram_q_i,
  output port_t                   dbg_last_grant
);

  logic [1:0]              gnt;
  port_t                   win;
  logic                    win_we;
  logic [DATA_WIDTH/8-1:0] win_be;
  logic [ADDR_WIDTH+1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic                    addr_lsb_unused;
  rsp_tag_t                tag_q;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk        (clk),
    .rst_i      (rst_i),
    .req        ({p1_req_i, p0_req_i}),
    .gnt        (gnt),
    .last_grant (dbg_last_grant)
  );

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];
  assign win      = gnt[1];

  always_comb begin
    win_we    = p0_we_i;
    win_be    = p0_be_i;
    win_addr  = p0_addr_i;
    win_wdata = p0_wdata_i;
    if (win == PORT1) begin
      win_we    = p1_we_i;
      win_be    = p1_be_i;
      win_addr  = p1_addr_i;
      win_wdata = p1_wdata_i;
    end
  end

  // Byte-offset bits have no meaning for a word-addressed macro.
  assign addr_lsb_unused = ^win_addr[1:0];

  always_comb begin
    sram_cen_o  = 1'b1;
    sram_gwen_o = 1'b1;
    sram_ben_o  = '1;
    sram_a_o    = '0;
    sram_d_o    = '0;
    if (gnt != 2'b00) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = ~win_we;
      sram_ben_o  = win_we ? ~win_be : '1;
      sram_a_o    = win_addr[ADDR_WIDTH+1:2];
      sram_d_o    = win_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      tag_q <= '0;
    end else begin
      tag_q.valid <= (gnt != 2'b00);
      tag_q.port  <= win;
      tag_q.we    <= win_we;
    end
  end

  // A reset landing in the response cycle kills the pending response.
  assign rsp_valid   = tag_q.valid & ~rst_i;
  assign rsp_data    = tag_q.we ? '0 : sram_q_i;
  assign p0_rvalid_o = rsp_valid & (tag_q.port == PORT0);
  assign p1_rvalid_o = rsp_valid & (tag_q.port == PORT1);
  assign p0_rdata_o  = p0_rvalid_o ? rsp_data : '0;
  assign p1_rdata_o  = p1_rvalid_o ? rsp_data : '0;

endmodule
